// File: rtl/scan_pkg.sv
// Shared definitions for the scan chain controller: FSM state encoding and
// the NbarT mode levels driven onto the chain.
package scan_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      CAPTURE = 3'd2,
      UNLOAD  = 3'd3,
      DONE    = 3'd4
   } scan_state_t;

   // NbarT levels: 1 selects the scan (shift) path, 0 the functional D input.
   localparam logic SCAN_SHIFT = 1'b1;
   localparam logic SCAN_FUNC  = 1'b0;

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load shift register: load has priority over shift; shifting moves
// data toward bit 0, so bit 0 is the serial output and sin enters at the MSB.
module scan_shift_reg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift,
   input  logic             sin,
   output logic [WIDTH-1:0] q
);

   // Register: parallel load wins, otherwise one right shift per enabled cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (load)
         q <= load_data;
      else if (shift)
         q <= {sin, q[WIDTH-1:1]};
   end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: loads a pattern through Si with NbarT=1, applies
// CAPTURE_CYCLES functional clocks, then unloads the chain tail into response.
// The chain is left in functional mode (NbarT=0) whenever the controller idles.
module scan_chain_ctrl
   import scan_pkg::*;
#(
   parameter int unsigned CHAIN_LEN      = 32,
   parameter int unsigned CAPTURE_CYCLES = 1,
   parameter int unsigned CNT_W          = $clog2(CHAIN_LEN + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CHAIN_LEN-1:0] pattern,
   input  logic                 abort,
   input  logic                 so,
   output logic                 ready,
   output logic                 NbarT,
   output logic                 Si,
   output logic                 busy,
   output logic                 done,
   output logic [CHAIN_LEN-1:0] response
);

   // The counter also times the capture window (up to 15 clocks), so it is
   // never narrower than 4 bits even for very short chains.
   localparam int unsigned      CW       = (CNT_W < 4) ? 4 : CNT_W;
   localparam logic [CW-1:0]    LEN_LAST = CW'(CHAIN_LEN - 1);
   localparam logic [CW-1:0]    CAP_LAST = CW'(CAPTURE_CYCLES - 1);

   scan_state_t          state, state_d;
   logic [CW-1:0]        cnt, cnt_d;
   logic                 nbart_d;
   logic                 accept;
   logic                 kill;
   logic                 resp_we;
   logic [CHAIN_LEN-1:0] pat_q;
   logic [CHAIN_LEN-1:0] pat_load;
   logic [CHAIN_LEN-1:0] resp_ins;
   logic                 unused_pat_hi;

   // abort outranks start in IDLE; abort only cancels an active sequence.
   assign accept  = (state == IDLE) && start && !abort;
   assign kill    = abort && ((state == LOAD) || (state == CAPTURE) || (state == UNLOAD));
   assign resp_we = (state == UNLOAD) && !abort;

   assign ready = (state == IDLE);
   assign busy  = (state != IDLE);
   assign done  = (state == DONE);

   // Si is the pattern register LSB, so it is a flop output. Shifting in zeros
   // drains the register to all-zero after CHAIN_LEN shifts, which keeps Si low
   // outside LOAD; an abort reloads zeros for the same reason.
   assign pat_load = accept ? pattern : '0;
   assign Si       = pat_q[0];

   // Upper pattern bits are consumed only by the shift path inside the register.
   assign unused_pat_hi = ^pat_q[CHAIN_LEN-1:1];

   scan_shift_reg #(
      .WIDTH(CHAIN_LEN)
   ) u_pattern_sr (
      .clk      (clk),
      .rst      (rst),
      .load     (accept || kill),
      .load_data(pat_load),
      .shift    (state == LOAD),
      .sin      (1'b0),
      .q        (pat_q)
   );

   // Response word with the bit for the current unload position replaced by so;
   // bits already unloaded stay put, so an abort leaves a partial update.
   always_comb begin
      resp_ins = response;
      for (int unsigned i = 0; i < CHAIN_LEN; i++) begin
         if (cnt == CW'(i))
            resp_ins[i] = so;
      end
   end

   scan_shift_reg #(
      .WIDTH(CHAIN_LEN)
   ) u_response_sr (
      .clk      (clk),
      .rst      (rst),
      .load     (resp_we),
      .load_data(resp_ins),
      .shift    (1'b0),
      .sin      (1'b0),
      .q        (response)
   );

   // State, counter and registered NbarT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         NbarT <= SCAN_FUNC;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         NbarT <= nbart_d;
      end
   end

   // Next state and counter; the counter restarts at zero on every state entry.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         LOAD: begin
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt == LEN_LAST) begin
               state_d = CAPTURE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         CAPTURE: begin
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt == CAP_LAST) begin
               state_d = UNLOAD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         UNLOAD: begin
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt == LEN_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      nbart_d = ((state_d == LOAD) || (state_d == UNLOAD)) ? SCAN_SHIFT : SCAN_FUNC;
   end

endmodule
